mem_ctrl: RTL

Byte-serial memory controller between the single-port RAM/IO bus and the two requesters above it: the instruction fetch stage (64-byte cache-block refills) and the load/store buffer (byte/half/word loads and stores). It latches requests, arbitrates between them, serialises each access into one-byte RAM cycles, and returns a full cache block or load word with a single-cycle valid pulse. Rollback aborts speculative work; committed stores always complete.

---
 rtl/mem_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller arbitrating instruction-block refills and load/store accesses.
// Optional macro MEMCTRL_IO_STALL_EN holds store cycles to the IO window while io_buffer_full is set.
module mem_ctrl #(
  parameter int unsigned BLK_BYTES  = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   if_find_valid,
  input  logic [ADDR_WIDTH-1:0]  if_find_addr,
  output logic                   if_data_valid,
  output logic [8*BLK_BYTES-1:0] if_data,
  input  logic                   lsb_valid,
  input  logic                   lsb_wr,
  input  logic [ADDR_WIDTH-1:0]  lsb_addr,
  input  logic [1:0]             lsb_len,
  input  logic [31:0]            lsb_wdata,
  output logic                   lsb_done,
  output logic [31:0]            lsb_rdata,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [ADDR_WIDTH-1:0]  mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StIfRead, StLsRead, StLsWrite} state_e;

  localparam logic [ADDR_WIDTH-1:0] BlkMask = ADDR_WIDTH'(BLK_BYTES - 1);

  state_e state_q, state_d;

  logic                   pend_if_q, pend_ls_q;
  logic [ADDR_WIDTH-1:0]  if_addr_q, ls_addr_q;
  logic                   ls_wr_q;
  logic [1:0]             ls_len_q;
  logic [31:0]            ls_wdata_q;

  logic [ADDR_WIDTH-1:0]  mem_a_q;
  logic [6:0]             cnt_q, n_q;
  logic [31:0]            wdata_q;
  logic [8*BLK_BYTES-1:0] if_data_q;
  logic                   if_data_valid_q, lsb_done_q;
  logic [31:0]            lsb_rdata_q;

  logic       start_ls, start_if, io_stall;
  logic [6:0] ls_n, slot;

`ifdef MEMCTRL_IO_STALL_EN
  assign io_stall = io_buffer_full && ((mem_a_q >> 16) == ADDR_WIDTH'(3));
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  // Byte slot filled by the data returning for the previously issued address.
  assign slot = cnt_q - 7'd1;

  always_comb begin
    case (ls_len_q)
      2'd0:    ls_n = 7'd1;
      2'd1:    ls_n = 7'd2;
      default: ls_n = 7'd4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_ls)      state_d = ls_wr_q ? StLsWrite : StLsRead;
        else if (start_if) state_d = StIfRead;
      end
      StIfRead, StLsRead: begin
        if (rollback || cnt_q == n_q) state_d = StIdle;
      end
      StLsWrite: begin
        if (!io_stall && cnt_q == n_q - 7'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start_ls = 1'b0;
    start_if = 1'b0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    if (state_q == StIdle) begin
      // A rolled-back pending load must not start; committed stores always do.
      start_ls = pend_ls_q && !(rollback && !ls_wr_q);
      start_if = pend_if_q && !pend_ls_q && !rollback;
    end
    if (state_q == StLsWrite && rdy && !io_stall) begin
      mem_wr   = 1'b1;
      mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_if_q       <= 1'b0;
      pend_ls_q       <= 1'b0;
      if_addr_q       <= '0;
      ls_addr_q       <= '0;
      ls_wr_q         <= 1'b0;
      ls_len_q        <= 2'd0;
      ls_wdata_q      <= 32'h0;
      mem_a_q         <= '0;
      cnt_q           <= 7'd0;
      n_q             <= 7'd0;
      wdata_q         <= 32'h0;
      if_data_q       <= '0;
      if_data_valid_q <= 1'b0;
      lsb_done_q      <= 1'b0;
      lsb_rdata_q     <= 32'h0;
    end else if (rdy) begin
      if_data_valid_q <= 1'b0;
      lsb_done_q      <= 1'b0;

      if (if_find_valid && !pend_if_q) begin
        pend_if_q <= 1'b1;
        if_addr_q <= if_find_addr;
      end
      if (start_if || rollback) pend_if_q <= 1'b0;

      if (lsb_valid && !pend_ls_q) begin
        pend_ls_q  <= 1'b1;
        ls_wr_q    <= lsb_wr;
        ls_addr_q  <= lsb_addr;
        ls_len_q   <= lsb_len;
        ls_wdata_q <= lsb_wdata;
      end
      if (start_ls || (rollback && pend_ls_q && !ls_wr_q)) pend_ls_q <= 1'b0;

      case (state_q)
        StIdle: begin
          cnt_q <= 7'd0;
          if (start_ls) begin
            mem_a_q <= ls_addr_q;
            n_q     <= ls_n;
            wdata_q <= ls_wdata_q;
            if (!ls_wr_q) lsb_rdata_q <= 32'h0;
          end else if (start_if) begin
            mem_a_q <= if_addr_q & ~BlkMask;
            n_q     <= 7'(BLK_BYTES);
          end
        end
        StIfRead, StLsRead: begin
          if (rollback) begin
            cnt_q <= 7'd0;
          end else begin
            if (cnt_q != 7'd0) begin
              if (state_q == StIfRead) if_data_q[{slot, 3'b000} +: 8] <= mem_din;
              else                     lsb_rdata_q[{slot[1:0], 3'b000} +: 8] <= mem_din;
            end
            if (cnt_q == n_q) begin
              cnt_q <= 7'd0;
              if (state_q == StIfRead) if_data_valid_q <= 1'b1;
              else                     lsb_done_q      <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 7'd1;
              // Address holds during the drain cycle.
              if (cnt_q + 7'd1 != n_q) mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
            end
          end
        end
        StLsWrite: begin
          if (!io_stall) begin
            if (cnt_q == n_q - 7'd1) begin
              cnt_q      <= 7'd0;
              lsb_done_q <= 1'b1;
            end else begin
              cnt_q   <= cnt_q + 7'd1;
              mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_a         = mem_a_q;
  assign if_data       = if_data_q;
  assign if_data_valid = if_data_valid_q;
  assign lsb_done      = lsb_done_q;
  assign lsb_rdata     = lsb_rdata_q;

endmodule
